arc4_ctrl: RTL and testbench
============================

// Module: arc4_ctrl
// PURPOSE
//   Top-level sequencer for one ARC4 decryption pass. On a start handshake it latches the key.
//   It then runs the init, ksa and prga engines strictly in order, each through their en/rdy handshakes.
//   It multiplexes the single S-memory write/address port to whichever engine owns the current phase.
//   Sits between the task top and the three engines; the S-memory q output fans out to all engines directly.
// PARAMETERS
//   TIMEOUT_CYCLES  4096  max cycles spent in any one phase (GO+BUSY+DONE waits) before error
// PORTS
//   clk           in   1   system clock
//   rst           in   1   synchronous, active-high reset
//   en            in   1   start request; accepted only when en && rdy
//   rdy           out  1   high when idle and able to accept en
//   key           in   24  decryption key, sampled on accept
//   key_q         out  24  latched key, driven to ksa and prga
//   done          out  1   one-cycle pulse when prga phase completes normally
//   err           out  1   sticky timeout flag; cleared on next accepted en or rst
//   init_en/ksa_en/prga_en     out 1 each  one-cycle start pulses to engines
//   init_rdy/ksa_rdy/prga_rdy  in  1 each  engine ready/idle indications
//   init_addr, ksa_addr, prga_addr        in 8 each  engine S addresses
//   init_wrdata, ksa_wrdata, prga_wrdata  in 8 each  engine S write data
//   init_wren, ksa_wren, prga_wren        in 1 each  engine S write enables
//   s_addr        out  8   muxed S-memory address
//   s_wrdata      out  8   muxed S-memory write data
//   s_wren        out  1   muxed S-memory write enable
// BEHAVIOUR
//   States: IDLE; per phase P in {INIT,KSA,PRGA}: P_GO, P_BUSY, P_DONE.
//   Reset values: state=IDLE, rdy=1, done=0, err=0, all *_en=0, key_q=0, s_wren=0, s_addr=0, s_wrdata=0, phase counter=0.
//   rst mid-operation: IDLE on the next edge; engine en pulses stop at once; S port released the same cycle.
//   rdy is combinational: 1 only in IDLE.
//   IDLE: if en, latch key to key_q, clear err, go INIT_GO. en while not IDLE is ignored.
//   P_GO: wait for P_rdy=1; in that cycle assert P_en for exactly one cycle; next state P_BUSY.
//   P_BUSY: wait for P_rdy=0 (engine acknowledged); then P_DONE.
//   P_DONE: wait for P_rdy=1; INIT->KSA_GO, KSA->PRGA_GO, PRGA->IDLE with done=1 for that one cycle.
//   Phase counter clears on entry to each P_GO and increments every cycle in P_GO/P_BUSY/P_DONE.
//   Timeout: counter reaching TIMEOUT_CYCLES -> err=1, all en low, IDLE next cycle.
//     Width: $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
//   Timeout takes priority over a same-cycle P_rdy transition; done is not pulsed.
//   S-port mux (combinational on state):
//     INIT_* -> init_* ; KSA_* -> ksa_* ; PRGA_* -> prga_*.
//     IDLE -> s_wren=0, s_addr=0, s_wrdata=0.
//     Non-owning engines' wren never reaches s_wren.
//   Latency: accept edge to init_en = 1 cycle if init_rdy already 1; each phase handoff adds 2 cycles of overhead.
// TESTING
//   T1 reset: rst=1 2 cycles -> rdy=1, err=0, done=0, s_wren=0, all *_en=0.
//   T2 full run, stub engines (rdy drops 1 cycle after en; busy 256/768/1000 cycles), key=24'h000018:
//     -> en pulses in order init, ksa, prga, one cycle each; key_q=24'h000018.
//     -> done pulses exactly once; rdy returns to 1.
//   T3 mux isolation: during KSA, stub init_wren=1 and prga_wren=1 with addr 8'hAA -> s_wren follows ksa_wren only, s_addr=ksa_addr.
//   T4 busy start: en=1 held during PRGA phase -> no re-latch of key, no extra init_en; one done pulse only.
//   T5 timeout: TIMEOUT_CYCLES=64, ksa stub never raises rdy again -> err=1, rdy=1 at cycle 64 of KSA; no done pulse; next en clears err.
//   T6 reset mid-KSA: rst=1 one cycle at KSA_BUSY -> next cycle state=IDLE, rdy=1, s_wren=0, ksa_en=0.

Source files
------------

// File: rtl/arc4_ctrl.sv
// ARC4 decryption pass sequencer: runs init, ksa and prga engines in order and
// hands the single S-memory write/address port to whichever engine owns the phase.
module arc4_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [23:0] key_q,
  output logic        done,
  output logic        err,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  init_wrdata,
  input  logic [7:0]  ksa_wrdata,
  input  logic [7:0]  prga_wrdata,
  input  logic        init_wren,
  input  logic        ksa_wren,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle,
    StInitGo, StInitBusy, StInitDone,
    StKsaGo,  StKsaBusy,  StKsaDone,
    StPrgaGo, StPrgaBusy, StPrgaDone
  } state_e;

  state_e          state_q, state_d;
  logic [23:0]     key_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  logic            go_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      err_q   <= err_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    err_d   = err_q;
    done_d  = 1'b0;
    timeout = (state_q != StIdle) && (cnt_q >= CntW'(TIMEOUT_CYCLES));
    // Timeout wins over any same-cycle engine handshake.
    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: if (en) begin
          key_d   = key;
          err_d   = 1'b0;
          state_d = StInitGo;
        end
        StInitGo:   if (init_rdy)  state_d = StInitBusy;
        StInitBusy: if (!init_rdy) state_d = StInitDone;
        StInitDone: if (init_rdy)  state_d = StKsaGo;
        StKsaGo:    if (ksa_rdy)   state_d = StKsaBusy;
        StKsaBusy:  if (!ksa_rdy)  state_d = StKsaDone;
        StKsaDone:  if (ksa_rdy)   state_d = StPrgaGo;
        StPrgaGo:   if (prga_rdy)  state_d = StPrgaBusy;
        StPrgaBusy: if (!prga_rdy) state_d = StPrgaDone;
        StPrgaDone: if (prga_rdy) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end

    go_entry = (state_d != state_q) &&
               (state_d == StInitGo || state_d == StKsaGo || state_d == StPrgaGo);
    if (state_d == StIdle || go_entry) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(TIMEOUT_CYCLES)) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    rdy      = (state_q == StIdle);
    done     = done_q;
    err      = err_q;
    init_en  = 1'b0;
    ksa_en   = 1'b0;
    prga_en  = 1'b0;
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    // rst releases the engines and the S port in the same cycle it is seen.
    if (!rst) begin
      if (!timeout) begin
        init_en = (state_q == StInitGo) && init_rdy;
        ksa_en  = (state_q == StKsaGo)  && ksa_rdy;
        prga_en = (state_q == StPrgaGo) && prga_rdy;
      end
      unique case (state_q)
        StInitGo, StInitBusy, StInitDone: begin
          s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren;
        end
        StKsaGo, StKsaBusy, StKsaDone: begin
          s_addr = ksa_addr; s_wrdata = ksa_wrdata; s_wren = ksa_wren;
        end
        StPrgaGo, StPrgaBusy, StPrgaDone: begin
          s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_ctrl.sv
// Directed bench for arc4_ctrl: stub engines with fixed busy lengths, a second
// instance with a short timeout for the hung-engine scenario.
module tb_arc4_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic [23:0] key0 = '0, key1 = 24'h000777;
  logic        rdy0, rdy1, done0, done1, err0, err1, swren0, swren1;
  logic [23:0] keyq0, keyq1;
  logic [7:0]  saddr0, saddr1, swd0, swd1;

  // Engine stubs: index k*3+e, k = instance, e = 0 init / 1 ksa / 2 prga.
  logic [5:0] sen;
  logic [5:0] srdy = '1;
  logic [5:0] hang = '0;
  int         blen [6];
  int         left [6];
  logic [7:0] eaddr [3];
  logic [7:0] ewd [3];
  logic [2:0] ewren = '0;

  arc4_ctrl dut0 (
    .clk(clk), .rst(rst), .en(en0), .rdy(rdy0), .key(key0), .key_q(keyq0),
    .done(done0), .err(err0),
    .init_en(sen[0]), .ksa_en(sen[1]), .prga_en(sen[2]),
    .init_rdy(srdy[0]), .ksa_rdy(srdy[1]), .prga_rdy(srdy[2]),
    .init_addr(eaddr[0]), .ksa_addr(eaddr[1]), .prga_addr(eaddr[2]),
    .init_wrdata(ewd[0]), .ksa_wrdata(ewd[1]), .prga_wrdata(ewd[2]),
    .init_wren(ewren[0]), .ksa_wren(ewren[1]), .prga_wren(ewren[2]),
    .s_addr(saddr0), .s_wrdata(swd0), .s_wren(swren0)
  );

  arc4_ctrl #(.TIMEOUT_CYCLES(64)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .key(key1), .key_q(keyq1),
    .done(done1), .err(err1),
    .init_en(sen[3]), .ksa_en(sen[4]), .prga_en(sen[5]),
    .init_rdy(srdy[3]), .ksa_rdy(srdy[4]), .prga_rdy(srdy[5]),
    .init_addr(eaddr[0]), .ksa_addr(eaddr[1]), .prga_addr(eaddr[2]),
    .init_wrdata(ewd[0]), .ksa_wrdata(ewd[1]), .prga_wrdata(ewd[2]),
    .init_wren(ewren[0]), .ksa_wren(ewren[1]), .prga_wren(ewren[2]),
    .s_addr(saddr1), .s_wrdata(swd1), .s_wren(swren1)
  );

  // rdy drops the cycle after en, stays low blen cycles, then returns (unless hung).
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        srdy[i] <= 1'b1;
        left[i] <= 0;
      end else if (sen[i]) begin
        srdy[i] <= 1'b0;
        left[i] <= blen[i] - 1;
      end else if (!srdy[i] && !hang[i]) begin
        if (left[i] == 0) srdy[i] <= 1'b1;
        else left[i] <= left[i] - 1;
      end
    end
  end

  // Event monitor: cyc holds the index of the current cycle.
  int         cyc = 0;
  int         n_en [3] = '{0, 0, 0};
  int         t_en [3] = '{0, 0, 0};
  int         t_acc = 0, n_done = 0, t_done = 0, n_done1 = 0, t1_ksa = -1;
  logic       dbl = 1'b0;
  logic [2:0] prev_en = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_en <= sen[2:0];
    for (int e = 0; e < 3; e++) begin
      if (sen[e]) begin
        n_en[e] <= n_en[e] + 1;
        t_en[e] <= cyc;
        if (prev_en[e]) dbl <= 1'b1;
      end
    end
    if (en0 && rdy0) t_acc <= cyc;
    if (done0) begin
      n_done <= n_done + 1;
      t_done <= cyc;
    end
    if (done1) n_done1 <= n_done1 + 1;
    if (sen[4]) t1_ksa <= cyc;
  end

  int checks = 0;
  int passed = 0;

  task automatic start0(input logic [23:0] k);
    @(negedge clk);
    key0 = k;
    en0  = 1'b1;
    @(negedge clk);
    en0  = 1'b0;
  endtask

  task automatic wait_done0(input int base, input int bound);
    int i;
    i = 0;
    while (n_done == base && i < bound) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (n_done == base) $display("FAIL wait_done: no done pulse within %0d cycles", bound);
    else passed++;
  endtask

  task automatic wait_en0(input int e, input int base, input int bound);
    int i;
    i = 0;
    while (n_en[e] == base && i < bound) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (n_en[e] == base) $display("FAIL wait_en%0d: no en pulse within %0d cycles", e, bound);
    else passed++;
  endtask

  task automatic test_reset();
    eaddr = '{8'h11, 8'h22, 8'h33};
    ewd   = '{8'h41, 8'h42, 8'h43};
    ewren = 3'b111;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) $display("FAIL rst_rdy: got %b want 1", rdy0); else passed++;
    checks++; if (err0 !== 1'b0) $display("FAIL rst_err: got %b want 0", err0); else passed++;
    checks++; if (done0 !== 1'b0) $display("FAIL rst_done: got %b want 0", done0); else passed++;
    checks++; if (swren0 !== 1'b0) $display("FAIL rst_swren: got %b want 0", swren0); else passed++;
    checks++; if (sen[2:0] !== 3'b000) $display("FAIL rst_en: got %b want 000", sen[2:0]);
    else passed++;
    checks++; if (keyq0 !== 24'h0) $display("FAIL rst_keyq: got %h want 000000", keyq0);
    else passed++;
    checks++; if (saddr0 !== 8'h00) $display("FAIL rst_saddr: got %h want 00", saddr0);
    else passed++;
    checks++; if (swd0 !== 8'h00) $display("FAIL rst_swdata: got %h want 00", swd0); else passed++;
    ewren = 3'b000;
  endtask

  task automatic test_full_run();
    int b0, b1, b2, bd;
    b0 = n_en[0]; b1 = n_en[1]; b2 = n_en[2]; bd = n_done;
    start0(24'h000018);
    wait_done0(bd, 3000);
    repeat (3) @(negedge clk);
    checks++; if (n_en[0] - b0 != 1) $display("FAIL run_init_cnt: got %0d want 1", n_en[0] - b0);
    else passed++;
    checks++; if (n_en[1] - b1 != 1) $display("FAIL run_ksa_cnt: got %0d want 1", n_en[1] - b1);
    else passed++;
    checks++; if (n_en[2] - b2 != 1) $display("FAIL run_prga_cnt: got %0d want 1", n_en[2] - b2);
    else passed++;
    checks++; if (t_en[0] != t_acc + 1)
      $display("FAIL run_init_lat: got %0d want %0d", t_en[0] - t_acc, 1); else passed++;
    checks++; if (t_en[1] != t_en[0] + 258)
      $display("FAIL run_ksa_lat: got %0d want 258", t_en[1] - t_en[0]); else passed++;
    checks++; if (t_en[2] != t_en[1] + 770)
      $display("FAIL run_prga_lat: got %0d want 770", t_en[2] - t_en[1]); else passed++;
    checks++; if (t_done != t_en[2] + 1002)
      $display("FAIL run_done_lat: got %0d want 1002", t_done - t_en[2]); else passed++;
    checks++; if (n_done - bd != 1) $display("FAIL run_done_cnt: got %0d want 1", n_done - bd);
    else passed++;
    checks++; if (dbl !== 1'b0) $display("FAIL run_en_width: got multi-cycle en pulse");
    else passed++;
    checks++; if (keyq0 !== 24'h000018) $display("FAIL run_keyq: got %h want 000018", keyq0);
    else passed++;
    checks++; if (rdy0 !== 1'b1 || done0 !== 1'b0)
      $display("FAIL run_idle: got rdy=%b done=%b want rdy=1 done=0", rdy0, done0); else passed++;
  endtask

  task automatic test_mux_and_busy_start();
    int b0, b1, b2, bd;
    b0 = n_en[0]; b1 = n_en[1]; b2 = n_en[2]; bd = n_done;
    start0(24'h123456);
    wait_en0(1, b1, 400);
    repeat (3) @(negedge clk);
    eaddr = '{8'hAA, 8'h5C, 8'hAA};
    ewd   = '{8'hE1, 8'hC3, 8'hE2};
    ewren = 3'b101;
    #1;
    checks++; if (swren0 !== 1'b0) $display("FAIL mux_wren_off: got %b want 0", swren0);
    else passed++;
    checks++; if (saddr0 !== 8'h5C) $display("FAIL mux_addr: got %h want 5c", saddr0); else passed++;
    checks++; if (swd0 !== 8'hC3) $display("FAIL mux_wrdata: got %h want c3", swd0); else passed++;
    ewren = 3'b111;
    #1;
    checks++; if (swren0 !== 1'b1) $display("FAIL mux_wren_on: got %b want 1", swren0);
    else passed++;
    ewren = 3'b000;
    eaddr = '{8'h11, 8'h22, 8'h77};
    wait_en0(2, b2, 1000);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (saddr0 !== 8'h77) $display("FAIL mux_prga_addr: got %h want 77", saddr0);
    else passed++;
    @(negedge clk);
    en0  = 1'b1;
    key0 = 24'hABCDEF;
    repeat (20) @(negedge clk);
    checks++; if (rdy0 !== 1'b0) $display("FAIL busy_rdy: got %b want 0", rdy0); else passed++;
    en0 = 1'b0;
    wait_done0(bd, 1500);
    repeat (5) @(negedge clk);
    checks++; if (keyq0 !== 24'h123456) $display("FAIL busy_keyq: got %h want 123456", keyq0);
    else passed++;
    checks++; if (n_en[0] - b0 != 1) $display("FAIL busy_init_cnt: got %0d want 1", n_en[0] - b0);
    else passed++;
    checks++; if (n_done - bd != 1) $display("FAIL busy_done_cnt: got %0d want 1", n_done - bd);
    else passed++;
  endtask

  task automatic test_timeout();
    int i;
    hang[4] = 1'b1;
    @(negedge clk);
    en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    i = 0;
    while (t1_ksa < 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    checks++; if (t1_ksa < 0) $display("FAIL to_ksa_en: no ksa_en within 200 cycles");
    else passed++;
    i = 0;
    while (cyc < t1_ksa + 64 && i < 200) begin
      @(negedge clk);
      i++;
    end
    checks++; if (err1 !== 1'b0 || rdy1 !== 1'b0)
      $display("FAIL to_early: got err=%b rdy=%b want err=0 rdy=0", err1, rdy1); else passed++;
    @(negedge clk);
    checks++; if (err1 !== 1'b1 || rdy1 !== 1'b1)
      $display("FAIL to_flag: got err=%b rdy=%b want err=1 rdy=1", err1, rdy1); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (err1 !== 1'b1) $display("FAIL to_sticky: got %b want 1", err1); else passed++;
    checks++; if (n_done1 != 0) $display("FAIL to_no_done: got %0d want 0", n_done1); else passed++;
    en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    checks++; if (err1 !== 1'b0) $display("FAIL to_clear: got %b want 0", err1); else passed++;
  endtask

  task automatic test_reset_mid_ksa();
    int b1;
    b1 = n_en[1];
    start0(24'h0000AB);
    wait_en0(1, b1, 400);
    repeat (3) @(negedge clk);
    ewren = 3'b010;
    rst   = 1'b1;
    #1;
    checks++; if (swren0 !== 1'b0) $display("FAIL mid_rst_swren: got %b want 0", swren0);
    else passed++;
    checks++; if (saddr0 !== 8'h00) $display("FAIL mid_rst_saddr: got %h want 00", saddr0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b1) $display("FAIL mid_rdy: got %b want 1", rdy0); else passed++;
    checks++; if (swren0 !== 1'b0 || sen[1] !== 1'b0)
      $display("FAIL mid_idle: got swren=%b ksa_en=%b want 0 0", swren0, sen[1]); else passed++;
    ewren = 3'b000;
  endtask

  initial begin
    blen = '{256, 768, 1000, 5, 5, 5};
    test_reset();
    test_full_run();
    test_mux_and_busy_start();
    test_timeout();
    test_reset_mid_ksa();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
